mux_arb_nx1: RTL and testbench

- Parametrised successor to the fixed 16:1 32-bit word multiplexer.
- Selects one of NUM_IN valid/ready input channels of WIDTH bits and forwards it through a single registered output stage.
- Two modes:
  - Explicit select, where the index comes from sel.
  - Round-robin arbitration.
- Used wherever several FP32/integer producers share one writeback or operand path.

---
 rtl/mux_arb_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/mux_arb_nx1.sv | 141 ++++++++++++++
 tb/tb_mux_arb_nx1.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and limits for the N:1 valid/ready mux-arbiter
package mux_arb_pkg;

  typedef enum logic {MUX_SEL = 1'b0, MUX_RR = 1'b1} mux_mode_e;

  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_e;

  localparam int MUX_ARB_MAX_IN = 64;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, priority starts at ptr
module rr_arbiter #(
  parameter int N = 16,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  localparam logic [PW:0] NW = (PW+1)'(N);

  logic [N-1:0]  rot;
  logic [PW-1:0] off;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          hit;

  // Rotate so ptr sits at bit 0, take the lowest request, then rotate the index back.
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    hit = 1'b0;
    for (int k = N-1; k >= 0; k--) begin
      if (rot[k]) begin
        hit = 1'b1;
        off = PW'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NW) begin
      sum = sum - NW;
    end
    idx = sum[PW-1:0];
    gnt = (en && hit) ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/mux_arb_nx1.sv
// rtl/mux_arb_nx1.sv - NUM_IN:1 valid/ready mux with explicit-select or round-robin grant
// Optional packet lock in round-robin mode: define MUX_ARB_PKT_LOCK_EN.
module mux_arb_nx1
  import mux_arb_pkg::*;
#(
  parameter int NUM_IN = 16,
  parameter int WIDTH  = 32,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
`ifdef MUX_ARB_PKT_LOCK_EN
  input  logic [NUM_IN-1:0]       in_last,
`endif
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready
);

  if (NUM_IN < 2 || NUM_IN > MUX_ARB_MAX_IN) begin : g_cfg_check
    $error("mux_arb_nx1: NUM_IN out of range");
  end

  out_state_e        state_q, state_d;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  ptr_next;
  logic [SEL_W-1:0]  gnt_idx;
  logic [WIDTH-1:0]  gnt_data;
  logic [NUM_IN-1:0] sel_gnt, rr_req, rr_gnt, gnt;
  logic              load, xfer, rr_mode, ptr_adv;

  assign rr_mode = (mux_mode_e'(mode) == MUX_RR);
  assign load    = (state_q == OUT_EMPTY) || out_ready;

  // An out-of-range sel matches no channel, so it yields no grant.
  always_comb begin
    sel_gnt = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(sel) == i) begin
        sel_gnt[i] = in_valid[i];
      end
    end
  end

`ifdef MUX_ARB_PKT_LOCK_EN
  logic             lock_q;
  logic [SEL_W-1:0] lock_idx_q;
  logic             last_g;

  assign last_g  = |(in_last & gnt);
  assign rr_req  = lock_q ? (in_valid & (NUM_IN'(1) << lock_idx_q)) : in_valid;
  assign ptr_adv = xfer && rr_mode && last_g;

  // Leaving round-robin mode drops any packet lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (!rr_mode) begin
      lock_q     <= 1'b0;
    end else if (xfer) begin
      lock_q     <= !last_g;
      lock_idx_q <= gnt_idx;
    end
  end
`else
  assign rr_req  = in_valid;
  assign ptr_adv = xfer && rr_mode;
`endif

  rr_arbiter #(
    .N   (NUM_IN)
  ) u_rr_arbiter (
    .req (rr_req),
    .ptr (rr_ptr),
    .en  (load && rr_mode),
    .gnt (rr_gnt)
  );

  assign gnt      = !load ? '0 : (rr_mode ? rr_gnt : sel_gnt);
  assign xfer     = |gnt;
  assign in_ready = rst ? '0 : gnt;

  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt[i]) begin
        gnt_idx  = SEL_W'(i);
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign ptr_next = (gnt_idx == SEL_W'(NUM_IN-1)) ? '0 : gnt_idx + SEL_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // FULL with out_ready and a new grant stays FULL: pass-through with no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (xfer) state_d = OUT_FULL;
      OUT_FULL:  if (out_ready && !xfer) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  assign out_valid = (state_q == OUT_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_src  <= '0;
    end else if (xfer) begin
      out_data <= gnt_data;
      out_src  <= gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (ptr_adv) begin
      rr_ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_mux_arb_nx1.sv
// tb/tb_mux_arb_nx1.sv - directed self-checking bench for mux_arb_nx1
module tb_mux_arb_nx1;

  localparam int NUM_IN = 16;
  localparam int WIDTH  = 32;
  localparam int SEL_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
`ifdef MUX_ARB_PKT_LOCK_EN
  logic [NUM_IN-1:0]       in_last;
`endif
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_ready;

  logic [WIDTH-1:0] ch [NUM_IN];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = ch[i];
  end

  mux_arb_nx1 #(.NUM_IN(NUM_IN), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef MUX_ARB_PKT_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic set_defaults();
    for (int i = 0; i < NUM_IN; i++) ch[i] = 32'hA000_0000 | i;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b0;
    mode = 1'b0;
    sel = '0;
`ifdef MUX_ARB_PKT_LOCK_EN
    in_last = '0;
`endif
    set_defaults();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = '0; in_valid = '1; out_ready = 1'b1;
`ifdef MUX_ARB_PKT_LOCK_EN
    in_last = '1;
`endif
    set_defaults();
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    checks++; if (out_src !== 4'd0) begin errors++; $display("FAIL rst_out_src got %0d exp 0", out_src); end
    checks++; if (in_ready !== 16'h0) begin errors++; $display("FAIL rst_in_ready got %h exp 0000", in_ready); end
    @(posedge clk); #1 rst = 1'b0; #1;
    checks++; if (in_ready !== 16'h0001) begin errors++; $display("FAIL rst_first_grant got %h exp 0001", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_src !== 4'd0) begin errors++; $display("FAIL rst_first_word got v=%b src=%0d exp v=1 src=0", out_valid, out_src); end
    checks++; if (out_data !== 32'hA000_0000) begin errors++; $display("FAIL rst_first_data got %h exp a0000000", out_data); end
  endtask

  task automatic test_explicit();
    do_reset();
    mode = 1'b0; sel = 4'd5; in_valid = 16'hFFFF; ch[5] = 32'hDEADBEEF; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 16'h0020) begin errors++; $display("FAIL sel_in_ready got %h exp 0020", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sel_out_data got %h exp deadbeef", out_data); end
    checks++; if (out_src !== 4'd5 || out_valid !== 1'b1) begin errors++; $display("FAIL sel_out_src got v=%b src=%0d exp v=1 src=5", out_valid, out_src); end
    in_valid = 16'hFFDF;
    #1;
    checks++; if (in_ready !== 16'h0000) begin errors++; $display("FAIL sel_invalid_ready got %h exp 0000", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sel_no_xfer got out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_rr_fairness();
    int seq [6] = '{2, 7, 15, 2, 7, 15};
    do_reset();
    mode = 1'b1; in_valid = 16'h8084; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 16'h0004) begin errors++; $display("FAIL rr_first_ready got %h exp 0004", in_ready); end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_src !== 4'(seq[k]) || out_data !== (32'hA000_0000 | seq[k])) begin
        errors++;
        $display("FAIL rr_word%0d got v=%b src=%0d data=%h exp v=1 src=%0d", k, out_valid, out_src, out_data, seq[k]);
      end
      checks++;
      if (in_ready !== (16'h1 << seq[(k+1)%3])) begin
        errors++;
        $display("FAIL rr_ready%0d got %h exp %h", k, in_ready, 16'h1 << seq[(k+1)%3]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; sel = 4'd3; ch[3] = 32'h12345678; in_valid = 16'h0008; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_data !== 32'h12345678 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_load got v=%b data=%h exp v=1 data=12345678", out_valid, out_data); end
    out_ready = 1'b0; ch[3] = 32'h87654321;
    #1;
    checks++; if (in_ready !== 16'h0) begin errors++; $display("FAIL bp_ready_stall got %h exp 0000", in_ready); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_data !== 32'h12345678 || out_valid !== 1'b1 || out_src !== 4'd3 || in_ready !== 16'h0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b data=%h src=%0d rdy=%h exp v=1 data=12345678 src=3 rdy=0000", k, out_valid, out_data, out_src, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 16'h0008) begin errors++; $display("FAIL bp_release_ready got %h exp 0008", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_data !== 32'h87654321 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_pass_through got v=%b data=%h exp v=1 data=87654321", out_valid, out_data); end
    in_valid = '0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_drain();
    do_reset();
    mode = 1'b1; in_valid = 16'h0040; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_src !== 4'd6) begin errors++; $display("FAIL drain_load got v=%b src=%0d exp v=1 src=6", out_valid, out_src); end
    in_valid = '0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_fall got out_valid=%b exp 0", out_valid); end
    @(posedge clk); #1;
    in_valid = 16'h0120;
    #1;
    checks++; if (in_ready !== 16'h0100) begin errors++; $display("FAIL drain_ptr_kept got %h exp 0100", in_ready); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1'b0; sel = 4'd9; in_valid = 16'h0200; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = '1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 4'd0 || in_ready !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid got v=%b data=%h src=%0d rdy=%h exp all zero", out_valid, out_data, out_src, in_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    mode = 1'b1; out_ready = 1'b1; in_valid = 16'h8001;
    #1;
    checks++; if (in_ready !== 16'h0001) begin errors++; $display("FAIL rst_mid_ptr got %h exp 0001", in_ready); end
  endtask

`ifdef MUX_ARB_PKT_LOCK_EN
  task automatic test_pkt_lock();
    int exp_src [4] = '{3, 3, 3, 4};
    logic [NUM_IN-1:0] last_seq [4] = '{16'h0010, 16'h0010, 16'h0018, 16'h0018};
    do_reset();
    mode = 1'b1; in_valid = 16'h0018; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_last = last_seq[k];
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_src !== 4'(exp_src[k])) begin
        errors++;
        $display("FAIL lock_word%0d got v=%b src=%0d exp v=1 src=%0d", k, out_valid, out_src, exp_src[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_explicit();
    test_rr_fairness();
    test_backpressure();
    test_drain();
    test_reset_mid();
`ifdef MUX_ARB_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
